// File: rtl/commit_trace_buf.sv
// commit_trace_buf: in-order FIFO of retire records between the writeback
// stage and the trace bridge. It also owns stop/halt sequencing, the retired
// instruction counter and a no-commit watchdog.
module commit_trace_buf #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        in_rf_wen,
  input  logic [4:0]  in_rf_wnum,
  input  logic [63:0] in_rf_wdata,
  input  logic        in_exp,
  input  logic        in_mret,
  input  logic        stop,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_rf_wen,
  output logic [4:0]  out_rf_wnum,
  output logic [63:0] out_rf_wdata,
  output logic        out_exp,
  output logic        out_mret,
  output logic        halt,
  output logic        overflow,
  output logic        hang,
  output logic [63:0] retired
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [WW-1:0] WD_ONE    = WW'(1);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rf_wen;
    logic [4:0]  rf_wnum;
    logic [63:0] rf_wdata;
    logic        exp;
    logic        mret;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          in_rec;
  rec_t          head_rec;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          stop_pending_reg;
  logic          halt_reg;
  logic          halt_next;
  logic          overflow_reg;
  logic          hang_reg;
  logic [63:0]   retired_reg;
  logic [WW-1:0] wd_reg;
  logic [WW-1:0] wd_next;
  logic          push;
  logic          pop;

  // Handshake: a full FIFO still accepts when the head leaves this cycle.
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count_reg < DEPTH_C) || pop;
  assign push      = in_valid && in_ready;

  assign in_rec = '{pc: in_pc, inst: in_inst, rf_wen: in_rf_wen, rf_wnum: in_rf_wnum,
                    rf_wdata: in_rf_wdata, exp: in_exp, mret: in_mret};

  assign head_rec     = mem[rd_ptr_reg];
  assign out_pc       = head_rec.pc;
  assign out_inst     = head_rec.inst;
  assign out_rf_wen   = head_rec.rf_wen;
  assign out_rf_wnum  = head_rec.rf_wnum;
  assign out_rf_wdata = head_rec.rf_wdata;
  assign out_exp      = head_rec.exp;
  assign out_mret     = head_rec.mret;

  assign halt     = halt_reg;
  assign overflow = overflow_reg;
  assign hang     = hang_reg;
  assign retired  = retired_reg;

  // Next halt and watchdog values; the watchdog is held at zero once halted.
  always_comb begin
    halt_next = halt_reg || (stop_pending_reg && (count_reg == '0) && !push);
    wd_next   = wd_reg;
    if (push || halt_reg) begin
      wd_next = '0;
    end else if (wd_reg != TIMEOUT_C) begin
      wd_next = wd_reg + WD_ONE;
    end
  end

  // Record storage: payload needs no reset, contents are only visible while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_rec;
    end
  end

  // Pointers, occupancy and all sticky status/counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      stop_pending_reg <= 1'b0;
      halt_reg         <= 1'b0;
      overflow_reg     <= 1'b0;
      hang_reg         <= 1'b0;
      retired_reg      <= '0;
      wd_reg           <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
        retired_reg <= retired_reg + 64'd1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_ONE;
      end
      if (stop) begin
        stop_pending_reg <= 1'b1;
      end
      if (in_valid && !in_ready) begin
        overflow_reg <= 1'b1;
      end
      halt_reg <= halt_next;
      wd_reg   <= wd_next;
      if (!halt_next && (wd_next == TIMEOUT_C)) begin
        hang_reg <= 1'b1;
      end
    end
  end

endmodule
